// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and condition evaluation for the decode/execute slice.
package y86_pkg;

  localparam int unsigned W    = 64;
  localparam int unsigned NREG = 15;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [1:0] A_ADD = 2'd0;
  localparam logic [1:0] A_SUB = 2'd1;
  localparam logic [1:0] A_AND = 2'd2;
  localparam logic [1:0] A_XOR = 2'd3;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] RRSP  = 4'd4;
  localparam logic [3:0] RNONE = 4'd15;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // Branch / conditional-move predicate from the flags.
  function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
    logic lt;
    cond_eval = 1'b0;
    lt = cc.sf ^ cc.of;
    case (ifun)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | cc.zf;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = cc.zf;
      C_NE:     cond_eval = !cc.zf;
      C_GE:     cond_eval = !lt;
      C_G:      cond_eval = !lt & !cc.zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15-entry register file: two read ports, a debug read port and two write ports.
module y86_regfile
  import y86_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   src_a,
  input  logic [3:0]   src_b,
  input  logic [3:0]   dbg_sel,
  output logic [W-1:0] val_a,
  output logic [W-1:0] val_b,
  output logic [W-1:0] dbg_val,
  input  logic         we_e,
  input  logic [3:0]   dst_e,
  input  logic [W-1:0] wdata_e,
  input  logic         we_m,
  input  logic [3:0]   dst_m,
  input  logic [W-1:0] wdata_m
);

  logic [W-1:0] regs [NREG];

  // Memory-port write takes precedence when both ports target one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (we_m && dst_m == 4'(i))      regs[i] <= wdata_m;
        else if (we_e && dst_e == 4'(i)) regs[i] <= wdata_e;
      end
    end
  end

  // Id 15 matches no entry, so it reads as zero.
  always_comb begin
    val_a   = '0;
    val_b   = '0;
    dbg_val = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (src_a == 4'(i))   val_a   = regs[i];
      if (src_b == 4'(i))   val_b   = regs[i];
      if (dbg_sel == 4'(i)) dbg_val = regs[i];
    end
  end

endmodule

// File: rtl/y86_decode_execute_unit.sv
// Y86-64 decode/execute stages with forwarding, condition codes and hazard control.
module y86_decode_execute_unit
  import y86_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   D_stat,
  input  logic [3:0]   D_icode,
  input  logic [3:0]   D_ifun,
  input  logic [3:0]   D_rA,
  input  logic [3:0]   D_rB,
  input  logic [W-1:0] D_valC,
  input  logic [W-1:0] D_valP,
  input  logic [1:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   M_icode,
  input  logic [3:0]   M_dstE,
  input  logic [3:0]   M_dstM,
  input  logic [W-1:0] M_valE,
  input  logic [W-1:0] m_valM,
  input  logic [1:0]   m_stat,
  input  logic [1:0]   W_stat,
  input  logic [3:0]   W_dstE,
  input  logic [3:0]   W_dstM,
  input  logic [W-1:0] W_valE,
  input  logic [W-1:0] W_valM,
  output logic [1:0]   d_stat,
  output logic [3:0]   d_icode,
  output logic [3:0]   d_ifun,
  output logic [3:0]   d_srcA,
  output logic [3:0]   d_srcB,
  output logic [3:0]   d_dstE,
  output logic [3:0]   d_dstM,
  output logic [W-1:0] d_valA,
  output logic [W-1:0] d_valB,
  output logic [W-1:0] d_valC,
  output logic [1:0]   e_stat,
  output logic [3:0]   e_icode,
  output logic [3:0]   e_dstE,
  output logic [3:0]   e_dstM,
  output logic [W-1:0] e_valE,
  output logic [W-1:0] e_valA,
  output logic         e_cnd,
  output logic         ZF,
  output logic         SF,
  output logic         OF,
  output logic         F_stall,
  output logic         D_stall,
  output logic         D_bubble,
  output logic         E_bubble,
  output logic         M_bubble,
  output logic         W_stall,
  input  logic [3:0]   dbg_sel,
  output logic [W-1:0] dbg_val
);

  localparam logic [W-1:0] STACK_STEP = W'(8);

  logic [W-1:0] rf_a, rf_b, alu_a, alu_b;
  logic [1:0]   alu_fn;
  logic         alu_of, set_cc, loaduse, ret_in_flight, mispredict;
  cc_t          cc, cc_next;

  y86_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .src_a   (d_srcA),
    .src_b   (d_srcB),
    .dbg_sel (dbg_sel),
    .val_a   (rf_a),
    .val_b   (rf_b),
    .dbg_val (dbg_val),
    .we_e    (W_stat == S_AOK && W_dstE != RNONE),
    .dst_e   (W_dstE),
    .wdata_e (W_valE),
    .we_m    (W_stat == S_AOK && W_dstM != RNONE),
    .dst_m   (W_dstM),
    .wdata_m (W_valM)
  );

  assign d_stat  = D_stat;
  assign d_icode = D_icode;
  assign d_ifun  = D_ifun;
  assign d_valC  = D_valC;

  // Register id selection per instruction class.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_RRMOV, I_RMMOV, I_OPQ, I_PUSH: d_srcA = D_rA;
      I_POP, I_RET:                    d_srcA = RRSP;
      default:                         d_srcA = RNONE;
    endcase
    case (D_icode)
      I_OPQ, I_RMMOV, I_MRMOV:         d_srcB = D_rB;
      I_PUSH, I_POP, I_CALL, I_RET:    d_srcB = RRSP;
      default:                         d_srcB = RNONE;
    endcase
    case (D_icode)
      I_RRMOV, I_IRMOV, I_OPQ:         d_dstE = D_rB;
      I_PUSH, I_POP, I_CALL, I_RET:    d_dstE = RRSP;
      default:                         d_dstE = RNONE;
    endcase
    if (D_icode == I_MRMOV || D_icode == I_POP) d_dstM = D_rA;
  end

  // Forwarding: youngest producer wins; RNONE never matches a tag.
  always_comb begin
    d_valA = rf_a;
    if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
    else if (d_srcA == RNONE)  d_valA = '0;
    else if (d_srcA == e_dstE) d_valA = e_valE;
    else if (d_srcA == M_dstM) d_valA = m_valM;
    else if (d_srcA == M_dstE) d_valA = M_valE;
    else if (d_srcA == W_dstM) d_valA = W_valM;
    else if (d_srcA == W_dstE) d_valA = W_valE;
  end

  always_comb begin
    d_valB = rf_b;
    if (d_srcB == RNONE)       d_valB = '0;
    else if (d_srcB == e_dstE) d_valB = e_valE;
    else if (d_srcB == M_dstM) d_valB = m_valM;
    else if (d_srcB == M_dstE) d_valB = M_valE;
    else if (d_srcB == W_dstM) d_valB = W_valM;
    else if (d_srcB == W_dstE) d_valB = W_valE;
  end

  // ALU operand and function selection.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = A_ADD;
    case (E_icode)
      I_RRMOV:          alu_a = E_valA;
      I_IRMOV:          alu_a = E_valC;
      I_RMMOV, I_MRMOV: begin alu_a = E_valC;      alu_b = E_valB; end
      I_OPQ:            begin alu_a = E_valA;      alu_b = E_valB; alu_fn = E_ifun[1:0]; end
      I_CALL, I_PUSH:   begin alu_a = -STACK_STEP; alu_b = E_valB; end
      I_RET, I_POP:     begin alu_a = STACK_STEP;  alu_b = E_valB; end
      default: ;
    endcase
  end

  always_comb begin
    e_valE = '0;
    alu_of = 1'b0;
    case (alu_fn)
      A_ADD: begin
        e_valE = alu_b + alu_a;
        alu_of = (alu_a[W-1] == alu_b[W-1]) && (e_valE[W-1] != alu_a[W-1]);
      end
      A_SUB: begin
        e_valE = alu_b - alu_a;
        alu_of = (alu_a[W-1] != alu_b[W-1]) && (e_valE[W-1] != alu_b[W-1]);
      end
      A_AND:   e_valE = alu_b & alu_a;
      default: e_valE = alu_b ^ alu_a;
    endcase
  end

  assign set_cc  = (E_icode == I_OPQ) && !M_bubble;
  assign cc_next = '{zf: (e_valE == '0), sf: e_valE[W-1], of: alu_of};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cc <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    else if (set_cc) cc <= cc_next;
  end

  assign ZF      = cc.zf;
  assign SF      = cc.sf;
  assign OF      = cc.of;
  assign e_cnd   = cond_eval(cc, E_ifun);
  assign e_dstE  = (E_icode == I_RRMOV && !e_cnd) ? RNONE : E_dstE;
  assign e_dstM  = E_dstM;
  assign e_valA  = E_valA;
  assign e_icode = E_icode;
  assign e_stat  = E_stat;

  // Pipeline control.
  assign loaduse       = (E_icode == I_MRMOV || E_icode == I_POP) && E_dstM != RNONE &&
                         (E_dstM == d_srcA || E_dstM == d_srcB);
  assign ret_in_flight = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mispredict    = (E_icode == I_JXX) && !e_cnd;
  assign F_stall       = loaduse | ret_in_flight;
  assign D_stall       = loaduse;
  assign D_bubble      = mispredict | (!loaduse & ret_in_flight);
  assign E_bubble      = mispredict | loaduse;
  assign M_bubble      = (m_stat != S_AOK) | (W_stat != S_AOK);
  assign W_stall       = (W_stat != S_AOK);

endmodule

// File: tb/tb_y86_decode_execute_unit.sv
// Randomized and directed checks of the Y86 decode/execute unit against a behavioural model.
module tb_y86_decode_execute_unit;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  D_stat, E_stat, m_stat, W_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, E_icode, E_ifun, E_dstE, E_dstM;
  logic [3:0]  M_icode, M_dstE, M_dstM, W_dstE, W_dstM, dbg_sel;
  logic [63:0] D_valC, D_valP, E_valA, E_valB, E_valC, M_valE, m_valM, W_valE, W_valM;
  logic [1:0]  d_stat, e_stat;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM, e_icode, e_dstE, e_dstM;
  logic [63:0] d_valA, d_valB, d_valC, e_valE, e_valA, dbg_val;
  logic        e_cnd, ZF, SF, OF, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural registers (entry 15 stays zero) and flags.
  logic [63:0] mreg [16];
  logic        mzf, msf, mof;
  // Reference outputs for the current input set.
  logic [3:0]  x_srcA, x_srcB, x_dstE, x_dstM, x_e_dstE;
  logic [63:0] x_valA, x_valB, x_valE;
  logic        x_cnd, x_of, x_setcc;
  logic [5:0]  x_haz;

  y86_decode_execute_unit dut (
    .clk(clk), .rst_n(rst_n),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .m_stat(m_stat), .W_stat(W_stat), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
    .e_stat(e_stat), .e_icode(e_icode), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .e_valE(e_valE), .e_valA(e_valA), .e_cnd(e_cnd), .ZF(ZF), .SF(SF), .OF(OF),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    case ($urandom_range(3, 0))
      0:       rnd64 = 64'($urandom_range(20, 0));
      1:       rnd64 = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(2, 0));
      2:       rnd64 = 64'h8000_0000_0000_0000 + 64'($urandom_range(2, 0));
      default: rnd64 = {$urandom, $urandom};
    endcase
  endfunction

  // True when the exact signed result lies outside the 64-bit two's complement range.
  function automatic logic ovf(input logic [63:0] a, input logic [63:0] b, input logic sub);
    logic signed [65:0] sa, sb, r;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    r  = sub ? sb - sa : sb + sa;
    ovf = (r > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (r < -66'sh0_8000_0000_0000_0000);
  endfunction

  function automatic logic [63:0] fwd(input logic [3:0] src);
    if (src == 4'd15)         fwd = 64'd0;
    else if (src == x_e_dstE) fwd = x_valE;
    else if (src == M_dstM)   fwd = m_valM;
    else if (src == M_dstE)   fwd = M_valE;
    else if (src == W_dstM)   fwd = W_valM;
    else if (src == W_dstE)   fwd = W_valE;
    else                      fwd = mreg[src];
  endfunction

  task automatic run_model();
    logic lt, lu, ret, mis, mb;
    x_of = 1'b0;
    case (E_icode)
      4'h2:       x_valE = E_valA;
      4'h3:       x_valE = E_valC;
      4'h4, 4'h5: x_valE = E_valB + E_valC;
      4'h8, 4'hA: x_valE = E_valB - 64'd8;
      4'h9, 4'hB: x_valE = E_valB + 64'd8;
      4'h6: case (E_ifun)
        4'd0:    begin x_valE = E_valB + E_valA; x_of = ovf(E_valA, E_valB, 1'b0); end
        4'd1:    begin x_valE = E_valB - E_valA; x_of = ovf(E_valA, E_valB, 1'b1); end
        4'd2:    x_valE = E_valB & E_valA;
        default: x_valE = E_valB ^ E_valA;
      endcase
      default:    x_valE = 64'd0;
    endcase
    lt = msf ^ mof;
    case (E_ifun)
      4'd0: x_cnd = 1'b1;
      4'd1: x_cnd = lt || mzf;
      4'd2: x_cnd = lt;
      4'd3: x_cnd = mzf;
      4'd4: x_cnd = !mzf;
      4'd5: x_cnd = !lt;
      4'd6: x_cnd = !lt && !mzf;
      default: x_cnd = 1'b0;
    endcase
    x_e_dstE = (E_icode == 4'h2 && !x_cnd) ? 4'd15 : E_dstE;
    x_srcA = (D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? D_rA : (D_icode inside {4'h9, 4'hB}) ? 4'd4 : 4'd15;
    x_srcB = (D_icode inside {4'h6, 4'h4, 4'h5}) ? D_rB : (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : 4'd15;
    x_dstE = (D_icode inside {4'h2, 4'h3, 4'h6}) ? D_rB : (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : 4'd15;
    x_dstM = (D_icode inside {4'h5, 4'hB}) ? D_rA : 4'd15;
    x_valA = (D_icode inside {4'h7, 4'h8}) ? D_valP : fwd(x_srcA);
    x_valB = fwd(x_srcB);
    lu  = (E_icode inside {4'h5, 4'hB}) && E_dstM != 4'd15 && (E_dstM == x_srcA || E_dstM == x_srcB);
    ret = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mis = (E_icode == 4'h7) && !x_cnd;
    mb  = (m_stat != 2'd0) || (W_stat != 2'd0);
    x_haz = {lu || ret, lu, mis || (!lu && ret), mis || lu, mb, W_stat != 2'd0};
    x_setcc = (E_icode == 4'h6) && !mb;
  endtask

  task automatic commit_model();
    if (x_setcc) begin mzf = (x_valE == 64'd0); msf = x_valE[63]; mof = x_of; end
    if (W_stat == 2'd0) begin
      if (W_dstE != 4'd15) mreg[W_dstE] = W_valE;
      if (W_dstM != 4'd15) mreg[W_dstM] = W_valM;
    end
  endtask

  task automatic tick();
    run_model();
    commit_model();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    D_stat = 0; D_icode = 4'h1; D_ifun = 0; D_rA = 15; D_rB = 15; D_valC = 0; D_valP = 0;
    E_stat = 0; E_icode = 4'h1; E_ifun = 0; E_dstE = 15; E_dstM = 15; E_valA = 0; E_valB = 0; E_valC = 0;
    M_icode = 4'h1; M_dstE = 15; M_dstM = 15; M_valE = 0; m_valM = 0; m_stat = 0;
    W_stat = 0; W_dstE = 15; W_dstM = 15; W_valE = 0; W_valM = 0; dbg_sel = 15;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 64'd0;
    mzf = 1'b1; msf = 1'b0; mof = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset(); #3;
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i); #1; checks++;
      if (dbg_val !== 64'd0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", i, dbg_val); end
    end
    checks++;
    if ({ZF, SF, OF} !== 3'b100) begin errors++; $display("FAIL reset_cc got %b want 100", {ZF, SF, OF}); end
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    idle(); W_dstE = 0; W_valE = 64'd10; tick();
    idle(); D_icode = 4'h2; D_rA = 0; D_rB = 3; #1; checks++;
    if (d_valA !== 64'd10) begin errors++; $display("FAIL rf_read got %0d want 10", d_valA); end
    idle(); W_dstE = 0; W_valE = 64'd99; tick();
    idle(); E_icode = 4'h3; E_valC = 64'd10; E_dstE = 0; D_icode = 4'h2; D_rA = 0; D_rB = 3; #1;
    checks++;
    if ({e_valE, d_valA} !== {64'd10, 64'd10}) begin
      errors++; $display("FAIL fwd_e got e_valE=%0d d_valA=%0d want 10 10", e_valE, d_valA);
    end
    idle(); W_dstE = 6; W_valE = 64'd1; W_dstM = 6; W_valM = 64'd2; tick();
    idle(); dbg_sel = 6; #1; checks++;
    if (dbg_val !== 64'd2) begin errors++; $display("FAIL wr_collision got %0d want 2", dbg_val); end
  endtask

  task automatic test_cc_branch();
    idle(); E_icode = 4'h6; E_ifun = 0; E_valA = 1; E_valB = 1; tick();
    E_ifun = 1; E_valA = 5; E_valB = 5; #1; checks++;
    if (e_valE !== 64'd0) begin errors++; $display("FAIL sub_zero got %h want 0", e_valE); end
    tick(); checks++;
    if ({ZF, SF, OF} !== 3'b100) begin errors++; $display("FAIL sub_cc got %b want 100", {ZF, SF, OF}); end
    idle(); E_icode = 4'h7; E_ifun = 4; #1; checks++;
    if ({e_cnd, D_bubble, E_bubble} !== 3'b011) begin
      errors++; $display("FAIL mispredict got %b want 011", {e_cnd, D_bubble, E_bubble});
    end
  endtask

  task automatic test_hazards();
    idle(); E_icode = 4'h5; E_dstM = 3; D_icode = 4'h6; D_rA = 3; D_rB = 1; #1; checks++;
    if ({F_stall, D_stall, E_bubble, D_bubble} !== 4'b1110) begin
      errors++; $display("FAIL loaduse got %b want 1110", {F_stall, D_stall, E_bubble, D_bubble});
    end
    idle(); D_icode = 4'h9; #1; checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1010) begin
      errors++; $display("FAIL ret got %b want 1010", {F_stall, D_stall, D_bubble, E_bubble});
    end
  endtask

  task automatic test_overflow_cmov();
    idle(); E_icode = 4'h6; E_ifun = 0; E_valB = 64'h7FFF_FFFF_FFFF_FFFF; E_valA = 1; #1; checks++;
    if (e_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_sum got %h", e_valE); end
    tick(); checks++;
    if ({ZF, SF, OF} !== 3'b011) begin errors++; $display("FAIL ovf_cc got %b want 011", {ZF, SF, OF}); end
    E_valB = 1; tick();
    idle(); E_icode = 4'h2; E_ifun = 1; E_dstE = 5; #1; checks++;
    if (e_dstE !== 4'd15) begin errors++; $display("FAIL cmovle got %0d want 15", e_dstE); end
    E_ifun = 4; #1; checks++;
    if (e_dstE !== 4'd5) begin errors++; $display("FAIL cmovne got %0d want 5", e_dstE); end
  endtask

  task automatic test_status();
    idle(); m_stat = 2'd2; E_icode = 4'h6; E_ifun = 1; E_valA = 5; E_valB = 5; #1; checks++;
    if (M_bubble !== 1'b1) begin errors++; $display("FAIL m_adr got %b want 1", M_bubble); end
    tick(); checks++;
    if ({ZF, SF, OF} !== 3'b000) begin errors++; $display("FAIL cc_hold got %b want 000", {ZF, SF, OF}); end
    idle(); W_dstE = 2; W_valE = 64'h1234; tick();
    idle(); W_stat = 2'd1; W_dstE = 2; W_valE = 64'hDEAD; W_dstM = 2; W_valM = 64'hBEEF; dbg_sel = 2; #1; checks++;
    if ({W_stall, M_bubble} !== 2'b11) begin errors++; $display("FAIL w_hlt got %b want 11", {W_stall, M_bubble}); end
    tick(); checks++;
    if (dbg_val !== 64'h1234) begin errors++; $display("FAIL w_hlt_nowrite got %h want 1234", dbg_val); end
  endtask

  task automatic test_random(input int n);
    for (int it = 0; it < n; it++) begin
      D_stat = 2'($urandom); D_icode = 4'($urandom_range(11, 0)); D_ifun = 4'($urandom);
      D_rA = 4'($urandom); D_rB = 4'($urandom); D_valC = rnd64(); D_valP = rnd64();
      E_stat = 2'($urandom); E_icode = 4'($urandom_range(11, 0));
      E_ifun = (E_icode == 4'h6) ? 4'($urandom_range(3, 0)) : 4'($urandom_range(6, 0));
      E_dstE = 4'($urandom); E_dstM = 4'($urandom);
      E_valA = rnd64(); E_valB = rnd64(); E_valC = rnd64();
      M_icode = 4'($urandom_range(11, 0)); M_dstE = 4'($urandom); M_dstM = 4'($urandom);
      M_valE = rnd64(); m_valM = rnd64();
      m_stat = ($urandom_range(5, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
      W_stat = ($urandom_range(5, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
      W_dstE = 4'($urandom); W_dstM = 4'($urandom); W_valE = rnd64(); W_valM = rnd64();
      dbg_sel = 4'($urandom);
      #1; run_model();
      checks++;
      if ({d_srcA, d_srcB, d_dstE, d_dstM} !== {x_srcA, x_srcB, x_dstE, x_dstM}) begin
        errors++; $display("FAIL rnd_ids it=%0d got %h want %h", it, {d_srcA, d_srcB, d_dstE, d_dstM}, {x_srcA, x_srcB, x_dstE, x_dstM});
      end
      checks++;
      if ({d_valA, d_valB} !== {x_valA, x_valB}) begin
        errors++; $display("FAIL rnd_dval it=%0d got %h %h want %h %h", it, d_valA, d_valB, x_valA, x_valB);
      end
      checks++;
      if ({d_stat, d_icode, d_ifun, d_valC} !== {D_stat, D_icode, D_ifun, D_valC}) begin
        errors++; $display("FAIL rnd_dpass it=%0d got %h", it, {d_stat, d_icode, d_ifun, d_valC});
      end
      checks++;
      if ({e_valE, e_cnd, e_dstE} !== {x_valE, x_cnd, x_e_dstE}) begin
        errors++; $display("FAIL rnd_exec it=%0d got %h %b %0d want %h %b %0d", it, e_valE, e_cnd, e_dstE, x_valE, x_cnd, x_e_dstE);
      end
      checks++;
      if ({e_stat, e_icode, e_dstM, e_valA} !== {E_stat, E_icode, E_dstM, E_valA}) begin
        errors++; $display("FAIL rnd_epass it=%0d got %h", it, {e_stat, e_icode, e_dstM, e_valA});
      end
      checks++;
      if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} !== x_haz) begin
        errors++; $display("FAIL rnd_haz it=%0d got %b want %b", it, {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, x_haz);
      end
      checks++;
      if ({ZF, SF, OF, dbg_val} !== {mzf, msf, mof, mreg[dbg_sel]}) begin
        errors++; $display("FAIL rnd_state it=%0d got %b %h want %b %h", it, {ZF, SF, OF}, dbg_val, {mzf, msf, mof}, mreg[dbg_sel]);
      end
      commit_model();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    @(posedge clk); #1;
    test_reset();
    test_forward();
    test_cc_branch();
    test_hazards();
    test_overflow_cmov();
    test_status();
    test_random(300);
    @(posedge clk); #1;
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
